// File: rtl/csc_coef_ctrl.sv
// Frame-synchronous coefficient bank controller for the RGB->YCbCr converter.
// A host-written shadow bank is copied to the active bank only at a vsync leading edge.
module csc_coef_ctrl #(
    parameter bit VS_POL = 1'b1,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              in_vsync,
    input  logic [3:0]        cfg_addr,
    input  logic [17:0]       cfg_wdata,
    input  logic              cfg_we,
    input  logic              cfg_commit,
    input  logic              cfg_restore,
    output logic              cfg_ready,
    output logic              cfg_pending,
    output logic [161:0]      coef_out,
    output logic [26:0]       offs_out,
    output logic              coef_update,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int COEF_W = 18;
    localparam int OFFS_W = 9;
    localparam int N_COEF = 9;
    localparam int N_OFFS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [COEF_W-1:0] coef_sh  [N_COEF];
    logic signed [OFFS_W-1:0] offs_sh  [N_OFFS];
    logic signed [COEF_W-1:0] coef_act [N_COEF];
    logic signed [OFFS_W-1:0] offs_act [N_OFFS];

    logic vs_act;
    logic vs_prev;
    logic vs_edge;

    // BT.601 full-range matrix in Q1.17, row-major Y / Cb / Cr.
    function automatic logic signed [COEF_W-1:0] coef_default(input int k);
        case (k)
            0:       return 18'sh09916;
            1:       return 18'sh12C8B;
            2:       return 18'sh03A5E;
            3:       return 18'sh3A99B;
            4:       return 18'sh35664;
            5:       return 18'sh10000;
            6:       return 18'sh10000;
            7:       return 18'sh329A1;
            8:       return 18'sh3D65E;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [OFFS_W-1:0] offs_default(input int j);
        case (j)
            1, 2:    return 9'sh080;
            default: return 9'sh000;
        endcase
    endfunction

    assign vs_act  = (in_vsync == VS_POL);
    assign vs_edge = ce & vs_act & ~vs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev   <= 1'b0;
            frame_cnt <= '0;
        end else if (ce) begin
            vs_prev <= vs_act;
            if (vs_edge) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // An edge in the commit cycle is seen while still IDLE, so it is never consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_commit) state_nxt = PENDING;
            PENDING: if (vs_edge)    state_nxt = APPLY;
            APPLY:                   state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready   = 1'b0;
        cfg_pending = 1'b0;
        coef_update = 1'b0;
        case (state)
            IDLE:    cfg_ready   = 1'b1;
            PENDING: cfg_pending = 1'b1;
            APPLY: begin
                cfg_pending = 1'b1;
                coef_update = 1'b1;
            end
            default: cfg_ready   = 1'b1;
        endcase
    end

    // Shadow bank: host-writable only while IDLE; restore beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_COEF; k++) coef_sh[k] <= coef_default(k);
            for (int j = 0; j < N_OFFS; j++) offs_sh[j] <= offs_default(j);
        end else if (ce && state == IDLE) begin
            if (cfg_restore) begin
                for (int k = 0; k < N_COEF; k++) coef_sh[k] <= coef_default(k);
                for (int j = 0; j < N_OFFS; j++) offs_sh[j] <= offs_default(j);
            end else if (cfg_we) begin
                for (int k = 0; k < N_COEF; k++) begin
                    if (cfg_addr == 4'(k)) coef_sh[k] <= cfg_wdata;
                end
                for (int j = 0; j < N_OFFS; j++) begin
                    if (cfg_addr == 4'(N_COEF + j)) offs_sh[j] <= cfg_wdata[OFFS_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_COEF; k++) coef_act[k] <= coef_default(k);
            for (int j = 0; j < N_OFFS; j++) offs_act[j] <= offs_default(j);
        end else if (ce && state == APPLY) begin
            for (int k = 0; k < N_COEF; k++) coef_act[k] <= coef_sh[k];
            for (int j = 0; j < N_OFFS; j++) offs_act[j] <= offs_sh[j];
        end
    end

    always_comb begin
        coef_out = '0;
        offs_out = '0;
        for (int k = 0; k < N_COEF; k++) coef_out[COEF_W*k +: COEF_W] = coef_act[k];
        for (int j = 0; j < N_OFFS; j++) offs_out[OFFS_W*j +: OFFS_W] = offs_act[j];
    end

endmodule

// File: doc/csc_coef_ctrl.md
Name: csc_coef_ctrl

Overview:
- Frame-synchronous configuration controller for the RGB->YCbCr colour-space converter in the skin-colour segmentation pipeline.
- Holds a host-writable shadow bank of 9 matrix coefficients (18-bit signed, Q1.17) and 3 offsets (9-bit signed).
- On commit, copies the shadow bank to the active bank only at the next vsync leading edge, so a frame is never converted with mixed coefficients.
- Counts frames and flags when an update is in flight.

Parameters:
- VS_POL, 1, active level of in_vsync (1 = active-high, 0 = active-low).
- FCNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  pipeline clock enable; all state advances only when ce=1
- in_vsync  in  1  video vsync, same timing as converter input
- cfg_addr  in  4  shadow register address
- cfg_wdata  in  18  write data; offsets use [8:0]
- cfg_we  in  1  write request
- cfg_commit  in  1  request shadow->active transfer at next frame boundary
- cfg_restore  in  1  reload shadow bank with defaults
- cfg_ready  out  1  controller accepts we/commit/restore
- cfg_pending  out  1  commit accepted, not yet applied
- coef_out  out  162  active coefs, addr k at bits [18k+17:18k]
- offs_out  out  27  active offsets, offset j (addr 9+j) at bits [9j+8:9j]
- coef_update  out  1  one-cycle pulse when the active bank changes
- frame_cnt  out  FCNT_W  vsync leading edges seen, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. rst has priority over ce.
- Address map (row-major):
  - 0..2: Y row (R, G, B); 3..5: Cb row; 6..8: Cr row.
  - 9, 10, 11: Y, Cb, Cr offsets.
  - 12..15: reserved; writes accepted but discarded.
- Defaults, applied to both shadow and active banks on reset:
  - Coefficients 0..8 = 0x09916, 0x12C8B, 0x03A5E, 0x3A99B, 0x35664, 0x10000, 0x10000, 0x329A1, 0x3D65E.
  - Offsets = 0x000, 0x080, 0x080.
- Reset values of other outputs: cfg_ready=1, cfg_pending=0, coef_update=0, frame_cnt=0; state=IDLE; vsync history register=inactive.
- Vsync edge detection:
  - vs_act = (in_vsync == VS_POL).
  - Edge = vs_act & ~vs_prev, evaluated only on ce=1 cycles; vs_prev updates only on ce=1 cycles.
  - Every edge increments frame_cnt, modulo 2^FCNT_W, in any state.
- State machine:
  - IDLE:
    - cfg_ready=1.
    - we: shadow[addr] <= wdata.
    - restore: shadow <= defaults.
    - If we and restore occur together, restore wins.
    - commit -> PENDING. A write in the same cycle lands in shadow and is included in the commit.
  - PENDING:
    - cfg_ready=0, cfg_pending=1.
    - we/commit/restore are ignored; shadow is frozen.
    - Edge -> APPLY.
    - An edge coinciding with the accepting commit cycle is not consumed; the transfer waits for the next edge.
  - APPLY (one ce cycle):
    - active <= shadow, coef_update=1 for exactly this cycle.
    - cfg_pending stays 1, cfg_ready=0.
    - Next state IDLE.
- Latency: edge detected at ce-cycle e. coef_out/offs_out show new values from the edge after cycle e+1. cfg_ready returns to 1 in the same cycle.
- ce=0: all registers hold, including coef_update (a pulse is stretched while ce=0). Inputs are ignored.
- Outputs are registered straight from the active bank; no combinational path from cfg_* to coef_out/offs_out.
- rst during PENDING or APPLY: the pending commit is dropped, both banks return to defaults, and no coef_update pulse is produced.

Test Plan:
- Reset, then read coef_out/offs_out -> coef[0]=0x09916, coef[8]=0x3D65E, offs=0x080/0x080/0x000 (bits 26:0 = {0x080,0x080,0x000}), cfg_ready=1, frame_cnt=0.
- Write addr 5 = 0x08000, no commit, toggle 3 frames of vsync -> coef_out unchanged, frame_cnt=3, coef_update never asserted.
- Write addr 5 = 0x08000 and addr 10 = 0x070, commit mid-frame -> cfg_pending=1, cfg_ready=0 until the next vsync rising edge. Two cycles later coef[5]=0x08000 and offs[1]=0x070, with a single coef_update pulse.
- During PENDING, drive cfg_we addr 0 = 0x00001 -> write ignored; after apply, coef[0] is still the committed shadow value.
- Commit in the same cycle as a vsync edge -> no transfer on that edge; transfer on the following frame's edge.
- Hold ce=0 across a vsync edge while PENDING -> no apply and no frame_cnt change. Assert rst while PENDING -> defaults restored, cfg_pending=0, no coef_update.
